// File: rtl/osc_mod_if.sv
// Sample-set handshake between the oscillator bank and the modulation engine.
// sat_flag exists only when MIX_SAT_EN is defined.
interface osc_mod_if #(
  parameter int M = 12,
  parameter int O = 16,
  parameter int N = 2
);
  logic [N*M-1:0] osc_in;
  logic [1:0]     mod_sel;
  logic           in_valid;
  logic           in_ready;
  logic [O-1:0]   out_data;
  logic           out_valid;
`ifdef MIX_SAT_EN
  logic           sat_flag;
`endif

  // A sample set transfers on a rising edge where in_valid && in_ready; the
  // result is qualified by a one-cycle out_valid pulse (no backpressure).
  modport master (
    output osc_in, mod_sel, in_valid,
`ifdef MIX_SAT_EN
    input  sat_flag,
`endif
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  osc_in, mod_sel, in_valid,
`ifdef MIX_SAT_EN
    output sat_flag,
`endif
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/osc_mod_engine.sv
// N-channel oscillator modulator: SUM / AM / XOR / ADIF on a small sequential datapath.
// Optional MIX_SAT_EN: SUM clamps to 2^M-1 and drives a sticky sat_flag.
module osc_mod_engine #(
  parameter int M = 12,
  parameter int O = 16,
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  osc_mod_if.slave   bus,
  output logic [1:0] dbgState
);
  localparam int AW = M + $clog2(N);
  localparam int PW = 2 * M;
  localparam int CW = $clog2(((N > M) ? N : M) + 1);

  localparam logic [1:0] MODE_SUM  = 2'b00;
  localparam logic [1:0] MODE_AM   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} stateT;

  stateT          state;
  logic           inReady;
  logic           outValid;
  logic [O-1:0]   outData;
  logic [N*M-1:0] oscLat;
  logic [1:0]     modeLat;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  mcand;
  logic [CW-1:0]  cnt;
`ifdef MIX_SAT_EN
  logic           satFlag;
`endif

  logic [AW-1:0]  sumNext;
  logic           sumOver;
  logic [M-1:0]   sumRes;
  logic [PW-1:0]  amNext;
  logic [M-1:0]   xorRes;
  logic [M-1:0]   adifRes;
  logic [O-1:0]   result;

  assign sumNext = acc[AW-1:0] + AW'(oscLat[M-1:0]);
  assign sumOver = |sumNext[AW-1:M];
`ifdef MIX_SAT_EN
  assign sumRes  = sumOver ? {M{1'b1}} : sumNext[M-1:0];
`else
  assign sumRes  = sumNext[M-1:0];
`endif
  // Multiplier bits are consumed LSB first from the ch1 slot as oscLat shifts right.
  assign amNext  = oscLat[M] ? (acc + mcand) : acc;
  assign adifRes = (oscLat[M-1:0] >= oscLat[2*M-1:M]) ? (oscLat[M-1:0] - oscLat[2*M-1:M])
                                                       : (oscLat[2*M-1:M] - oscLat[M-1:0]);

  always_comb begin
    xorRes = '0;
    for (int i = 0; i < N; i++) xorRes = xorRes ^ oscLat[i*M +: M];
  end

  always_comb begin
    result = '0;
    case (modeLat)
      MODE_SUM: result = {sumRes, {(O-M){1'b0}}};
      MODE_AM:  result = amNext[PW-1 -: O];
      MODE_XOR: result = {xorRes, {(O-M){1'b0}}};
      default:  result = {adifRes, {(O-M){1'b0}}};
    endcase
  end

  function automatic logic [CW-1:0] stepCount(input logic [1:0] mode);
    case (mode)
      MODE_SUM: return CW'(N);
      MODE_AM:  return CW'(M);
      default:  return CW'(1);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      outData  <= '0;
      oscLat   <= '0;
      modeLat  <= '0;
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
`ifdef MIX_SAT_EN
      satFlag  <= 1'b0;
`endif
    end else begin
      outValid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.in_valid) begin
            oscLat  <= bus.osc_in;
            modeLat <= bus.mod_sel;
            acc     <= '0;
            mcand   <= PW'(bus.osc_in[M-1:0]);
            cnt     <= stepCount(bus.mod_sel);
            inReady <= 1'b0;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          case (modeLat)
            MODE_SUM: begin
              acc    <= PW'(sumNext);
              oscLat <= oscLat >> M;
            end
            MODE_AM: begin
              acc    <= amNext;
              mcand  <= mcand << 1;
              oscLat <= oscLat >> 1;
            end
            default: ;
          endcase
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            outData  <= result;
            outValid <= 1'b1;
            inReady  <= 1'b1;
            state    <= DONE;
`ifdef MIX_SAT_EN
            if (modeLat == MODE_SUM && sumOver) satFlag <= 1'b1;
`endif
          end
        end
        default: begin
          inReady <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;
`ifdef MIX_SAT_EN
  assign bus.sat_flag  = satFlag;
`endif
  assign dbgState      = state;
endmodule

// File: tb/tb_osc_mod_engine.sv
// Directed bench for osc_mod_engine (M=12, O=16, N=2); expected results are hand-computed.
module tb_osc_mod_engine;
  localparam int M = 12;
  localparam int O = 16;
  localparam int N = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbgState;
  int         checks;
  int         errors;
  logic [O-1:0] exp_q[$];

  osc_mod_if #(.M(M), .O(O), .N(N)) bus ();

  osc_mod_engine #(.M(M), .O(O), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one set at a negedge; returns after the accepting edge (+1).
  task automatic drive_accept(input logic [M-1:0] ch0, input logic [M-1:0] ch1, input logic [1:0] mode);
    @(negedge clk);
    bus.osc_in   = {ch1, ch0};
    bus.mod_sel  = mode;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency, data against the scoreboard and the pulse width.
  task automatic wait_result(input string tag, input int expLat);
    int lat;
    logic [O-1:0] exp;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_val({tag, "_lat"}, lat, expLat);
    check_val({tag, "_data"}, bus.out_data, exp);
    check_val({tag, "_rdy"}, bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, bus.out_valid, 1'b0);
    check_val({tag, "_hold"}, bus.out_data, exp);
  endtask

  task automatic run_txn(input string tag, input logic [M-1:0] ch0, input logic [M-1:0] ch1,
                         input logic [1:0] mode, input logic [O-1:0] expData, input int expLat);
    exp_q.push_back(expData);
    drive_accept(ch0, ch1, mode);
    wait_result(tag, expLat);
  endtask

  initial begin
    int seen;
    int pos[3];
    checks = 0;
    errors = 0;
    bus.osc_in   = '0;
    bus.mod_sel  = 2'b00;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #23;
    check_val("rst_ready", bus.in_ready, 1'b1);
    check_val("rst_valid", bus.out_valid, 1'b0);
    check_val("rst_data", bus.out_data, 16'h0000);
    check_val("rst_state", dbgState, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SUM with explicit ready timing
    exp_q.push_back(16'hFFF0);
    drive_accept(12'h800, 12'h7FF, 2'b00);
    check_val("sum_rdy_k", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    check_val("sum_rdy_k1", bus.in_ready, 1'b0);
    check_val("sum_vld_k1", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_val("sum_vld_k2", bus.out_valid, 1'b1);
    check_val("sum_rdy_k2", bus.in_ready, 1'b1);
    check_val("sum_data", bus.out_data, exp_q.pop_front());

`ifdef MIX_SAT_EN
    run_txn("sum_ovf", 12'h800, 12'h900, 2'b00, 16'hFFF0, 2);
    check_val("sat_set", bus.sat_flag, 1'b1);
    run_txn("sum_after", 12'h001, 12'h002, 2'b00, 16'h0030, 2);
    check_val("sat_sticky", bus.sat_flag, 1'b1);
`else
    run_txn("sum_ovf", 12'h800, 12'h900, 2'b00, 16'h1000, 2);
    run_txn("sum_after", 12'h001, 12'h002, 2'b00, 16'h0030, 2);
`endif

    run_txn("am_max", 12'hFFF, 12'hFFF, 2'b01, 16'hFFE0, 12);
    run_txn("am_small", 12'h800, 12'h002, 2'b01, 16'h0010, 12);
    run_txn("am_zero", 12'h000, 12'h000, 2'b01, 16'h0000, 12);
    run_txn("xor", 12'hAAA, 12'h555, 2'b10, 16'hFFF0, 1);
    run_txn("adif_neg", 12'h100, 12'h300, 2'b11, 16'h2000, 1);
    run_txn("adif_pos", 12'h345, 12'h045, 2'b11, 16'h3000, 1);

    // Back-to-back XOR: in_valid held high across six edges
    @(negedge clk);
    bus.osc_in   = {12'h0F0, 12'h00F};
    bus.mod_sel  = 2'b10;
    bus.in_valid = 1'b1;
    seen = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        if (seen < 3) pos[seen] = e;
        seen++;
        check_val("b2b_data", bus.out_data, 16'h0FF0);
      end
    end
    bus.in_valid = 1'b0;
    check_val("b2b_count", seen, 3);
    check_val("b2b_pos0", pos[0], 1);
    check_val("b2b_pos1", pos[1], 3);
    check_val("b2b_pos2", pos[2], 5);
    @(posedge clk);
    #1;
    check_val("b2b_idle", dbgState, 2'd0);

    // In-flight input changes are ignored
    exp_q.push_back(16'h0010);
    drive_accept(12'h800, 12'h002, 2'b01);
    bus.osc_in  = {12'hFFF, 12'hFFF};
    bus.mod_sel = 2'b00;
    wait_result("am_latched", 12);

    // Reset during RUN step 5
    drive_accept(12'hFFF, 12'hFFF, 2'b01);
    repeat (5) @(posedge clk);
    #1;
    check_val("mid_state", dbgState, 2'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_rdy", bus.in_ready, 1'b1);
    check_val("mid_rst_data", bus.out_data, 16'h0000);
    check_val("mid_rst_vld", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check_val("mid_no_vld", seen, 0);
    check_val("mid_data_kept", bus.out_data, 16'h0000);
`ifdef MIX_SAT_EN
    check_val("sat_rst", bus.sat_flag, 1'b0);
`endif
    run_txn("post_rst", 12'h123, 12'h456, 2'b10, 16'h5750, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
